// File: rtl/multi_pulse_generator.sv
// Multi-channel PPS-disciplined pulse generator.
// Each channel arms on a matching time-of-day packet, waits for the next PPS edge, optionally
// delays by a microsecond offset and then emits a periodic pulse train (finite or endless).
// All channels share one PPS synchroniser and one microsecond divider so they stay phase-aligned.
module multi_pulse_generator #(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned CLKS_PER_1_US = 10,
   parameter int unsigned CNT_W         = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_pps_raw,
   input  logic [N_CH-1:0]       i_enable,
   input  logic                  i_tod_dv,
   input  logic [55:0]           i_tod,
   input  logic [55:0]           i_start_time,
   input  logic [N_CH*CNT_W-1:0] i_width_high,
   input  logic [N_CH*CNT_W-1:0] i_period,
   input  logic [N_CH*CNT_W-1:0] i_offset,
   input  logic [N_CH*CNT_W-1:0] i_count,
   output logic [N_CH-1:0]       o_pulse,
   output logic [N_CH-1:0]       o_busy,
   output logic [N_CH-1:0]       o_done
);

   localparam int unsigned      CLK_W    = (CLKS_PER_1_US > 1) ? $clog2(CLKS_PER_1_US) : 1;
   localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_1_US - 1);
   localparam logic [CLK_W-1:0] CLK_ONE  = CLK_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitTod,
      StWaitPps,
      StOffset,
      StRun,
      StHalt
   } state_e;

   // ---------------------------------------------------------------------------------------------
   // Shared PPS edge detection and microsecond divider
   // ---------------------------------------------------------------------------------------------
   logic [1:0]       pps_sync_q;
   logic             pps_dly_q;
   logic             pps_edge;
   logic [CLK_W-1:0] clk_cnt_q;
   logic [CLK_W-1:0] clk_cnt_d;
   logic             us_tick;
   logic             tod_match;

   assign pps_edge  = pps_sync_q[1] & ~pps_dly_q;
   assign us_tick   = (clk_cnt_q == CLK_LAST);
   assign tod_match = i_tod_dv && (i_tod == i_start_time);

   // Two-flop synchroniser for the asynchronous PPS, plus a delay flop for rising-edge detection
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pps_sync_q <= '0;
         pps_dly_q  <= 1'b0;
      end else begin
         pps_sync_q <= {pps_sync_q[0], i_pps_raw};
         pps_dly_q  <= pps_sync_q[1];
      end
   end

   // Divider restarts on every PPS edge so the microsecond grid is locked to PPS
   always_comb begin
      clk_cnt_d = clk_cnt_q + CLK_ONE;
      if (pps_edge || us_tick) begin
         clk_cnt_d = '0;
      end
   end

   // Divider state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         clk_cnt_q <= '0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Per-channel sequencer
   // ---------------------------------------------------------------------------------------------
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      state_e           state_q;
      state_e           state_d;
      logic [CNT_W-1:0] width_q;
      logic [CNT_W-1:0] width_d;
      logic [CNT_W-1:0] period_q;
      logic [CNT_W-1:0] period_d;
      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;
      logic [CNT_W-1:0] offset_q;
      logic [CNT_W-1:0] offset_d;
      logic [CNT_W-1:0] micro_q;
      logic [CNT_W-1:0] micro_d;
      logic [CNT_W-1:0] pulses_q;
      logic [CNT_W-1:0] pulses_d;
      logic             pulse_q;
      logic             done_q;
      logic             done_d;
      logic [CNT_W-1:0] cfg_width;
      logic [CNT_W-1:0] cfg_period;
      logic [CNT_W-1:0] cfg_offset;
      logic [CNT_W-1:0] cfg_count;
      logic             last_us;
      logic             last_pulse;

      assign cfg_width  = i_width_high[k*CNT_W +: CNT_W];
      assign cfg_period = i_period[k*CNT_W +: CNT_W];
      assign cfg_offset = i_offset[k*CNT_W +: CNT_W];
      assign cfg_count  = i_count[k*CNT_W +: CNT_W];

      // period_q is never 0 once latched, so period_q - 1 cannot underflow while running
      assign last_us    = (micro_q == period_q - CNT_ONE);
      assign last_pulse = (count_q != '0) && (pulses_q == count_q - CNT_ONE);

      // Next-state logic; a low enable wins over everything, including a completing train
      always_comb begin
         state_d  = state_q;
         width_d  = width_q;
         period_d = period_q;
         count_d  = count_q;
         offset_d = offset_q;
         micro_d  = micro_q;
         pulses_d = pulses_q;
         done_d   = 1'b0;

         if (!i_enable[k]) begin
            state_d = StIdle;
         end else begin
            case (state_q)
               StIdle: begin
                  state_d = StWaitTod;
               end
               StWaitTod: begin
                  if (tod_match) begin
                     state_d = StWaitPps;
                  end
               end
               StWaitPps: begin
                  if (pps_edge) begin
                     width_d  = cfg_width;
                     period_d = (cfg_period == '0) ? CNT_ONE : cfg_period;
                     count_d  = cfg_count;
                     offset_d = cfg_offset;
                     micro_d  = '0;
                     pulses_d = '0;
                     state_d  = (cfg_offset == '0) ? StRun : StOffset;
                  end
               end
               StOffset: begin
                  if (us_tick) begin
                     offset_d = offset_q - CNT_ONE;
                     if (offset_q == CNT_ONE) begin
                        micro_d = '0;
                        state_d = StRun;
                     end
                  end
               end
               StRun: begin
                  if (us_tick) begin
                     if (last_us) begin
                        micro_d  = '0;
                        pulses_d = pulses_q + CNT_ONE;
                        if (last_pulse) begin
                           state_d = StHalt;
                           done_d  = 1'b1;
                        end
                     end else begin
                        micro_d = micro_q + CNT_ONE;
                     end
                  end
               end
               StHalt: begin
                  state_d = StHalt;
               end
               default: begin
                  state_d = StIdle;
               end
            endcase
         end
      end

      // Channel state, shadow config and registered outputs
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            state_q  <= StIdle;
            width_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            offset_q <= '0;
            micro_q  <= '0;
            pulses_q <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            period_q <= period_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            micro_q  <= micro_d;
            pulses_q <= pulses_d;
            pulse_q  <= (state_q == StRun) && (micro_q < width_q);
            done_q   <= done_d;
         end
      end

      assign o_pulse[k] = pulse_q;
      assign o_done[k]  = done_q;
      assign o_busy[k]  = (state_q == StWaitPps) || (state_q == StOffset) || (state_q == StRun);
   end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator: expectations are pushed when stimulus is applied and
// popped when the corresponding DUT behaviour has been observed by the edge monitor.
module tb_multi_pulse_generator;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned CLKS  = 10;
   localparam int unsigned CNT_W = 32;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  pps = 1'b0;
   logic [N_CH-1:0]       enable = '0;
   logic                  tod_dv = 1'b0;
   logic [55:0]           tod = '0;
   logic [55:0]           start_time;
   logic [N_CH*CNT_W-1:0] width_high = '0;
   logic [N_CH*CNT_W-1:0] period = '0;
   logic [N_CH*CNT_W-1:0] offset = '0;
   logic [N_CH*CNT_W-1:0] count = '0;
   logic [N_CH-1:0]       o_pulse;
   logic [N_CH-1:0]       o_busy;
   logic [N_CH-1:0]       o_done;

   multi_pulse_generator #(
      .N_CH          (N_CH),
      .CLKS_PER_1_US (CLKS),
      .CNT_W         (CNT_W)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_pps_raw    (pps),
      .i_enable     (enable),
      .i_tod_dv     (tod_dv),
      .i_tod        (tod),
      .i_start_time (start_time),
      .i_width_high (width_high),
      .i_period     (period),
      .i_offset     (offset),
      .i_count      (count),
      .o_pulse      (o_pulse),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard
   typedef struct {
      string tag;
      int    exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       n_cmp  = 0;
   int       n_fail = 0;

   task automatic push(input string tag, input int exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic check(input int obs);
      sb_item_t it;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %0d required nothing queued", obs);
      end else begin
         it = sb_q.pop_front();
         assert (obs === it.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", it.tag, obs, it.exp);
         end
      end
   endtask

   // Edge monitor, sampled on the falling clock edge
   logic            clr = 1'b0;
   logic [N_CH-1:0] prev_p = '0;
   int n_rise[N_CH], rise0[N_CH], rise_last[N_CH], rise_prev[N_CH], high_last[N_CH];
   int fall_last[N_CH], n_done[N_CH], done_last[N_CH], done_run[N_CH], done_max[N_CH];

   always @(negedge clk) begin
      for (int k = 0; k < N_CH; k++) begin
         if (clr) begin
            n_rise[k]    <= 0;
            rise0[k]     <= 0;
            rise_last[k] <= 0;
            rise_prev[k] <= 0;
            high_last[k] <= 0;
            fall_last[k] <= 0;
            n_done[k]    <= 0;
            done_last[k] <= 0;
            done_run[k]  <= 0;
            done_max[k]  <= 0;
         end else begin
            if (o_pulse[k] && !prev_p[k]) begin
               if (n_rise[k] == 0) rise0[k] <= cyc;
               rise_prev[k] <= rise_last[k];
               rise_last[k] <= cyc;
               n_rise[k]    <= n_rise[k] + 1;
            end
            if (!o_pulse[k] && prev_p[k]) begin
               fall_last[k] <= cyc;
               high_last[k] <= cyc - rise_last[k];
            end
            if (o_done[k]) begin
               if (done_run[k] == 0) begin
                  n_done[k]    <= n_done[k] + 1;
                  done_last[k] <= cyc;
               end
               done_run[k] <= done_run[k] + 1;
               if (done_run[k] + 1 > done_max[k]) done_max[k] <= done_run[k] + 1;
            end else begin
               done_run[k] <= 0;
            end
         end
      end
      prev_p <= o_pulse;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int ch, input int w, input int p, input int off, input int cnt);
      width_high[ch*CNT_W +: CNT_W] = w;
      period[ch*CNT_W +: CNT_W]     = p;
      offset[ch*CNT_W +: CNT_W]     = off;
      count[ch*CNT_W +: CNT_W]      = cnt;
   endtask

   task automatic send_tod(input logic [55:0] val);
      tod    = val;
      tod_dv = 1'b1;
      step(1);
      tod_dv = 1'b0;
   endtask

   task automatic clear_stats();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   int c, c2, c3;

   initial begin
      start_time = {16'd2024, 8'd6, 8'd15, 8'd12, 8'd30, 8'd0};
      cfg(0, 3, 10, 0, 0);
      cfg(1, 2, 5, 7, 4);
      cfg(2, 0, 3, 0, 3);
      cfg(3, 12, 10, 0, 2);

      // Reset state
      step(3);
      push("rst_pulse", 0);
      push("rst_busy", 0);
      push("rst_done", 0);
      check(int'(o_pulse));
      check(int'(o_busy));
      check(int'(o_done));
      rst = 1'b0;
      step(1);

      // Non-matching TOD (seconds off by one) then PPS: nothing may start
      enable = 4'hF;
      step(2);
      clear_stats();
      send_tod(start_time + 56'd1);
      pps = 1'b1;
      step(3);
      pps = 1'b0;
      step(40);
      push("nomatch_busy", 0);
      push("nomatch_rises", 0);
      check(int'(o_busy));
      check(n_rise[0] + n_rise[1] + n_rise[2] + n_rise[3]);

      // Matching TOD arms all channels, PPS starts them
      send_tod(start_time);
      step(2);
      push("armed_busy", 4'hF);
      check(int'(o_busy));
      clear_stats();
      c = cyc;
      pps = 1'b1;
      push("ch0_rise0", c + 4);
      push("ch0_nrise", 5);
      push("ch0_high", 30);
      push("ch0_period", 100);
      push("ch1_rise0", c + 74);
      push("ch1_nrise", 4);
      push("ch1_high", 20);
      push("ch1_period", 50);
      push("ch1_done_t", c + 273);
      push("ch1_ndone", 1);
      push("ch1_done_len", 1);
      push("ch2_w0_nrise", 0);
      push("ch2_w0_done_t", c + 93);
      push("ch3_rise0", c + 4);
      push("ch3_const_high", 200);
      push("ch3_done_t", c + 203);
      push("halt_busy", 4'b0001);
      step(3);
      pps = 1'b0;
      step(147);
      // Second PPS mid-train only realigns the divider
      pps = 1'b1;
      step(3);
      pps = 1'b0;
      step(307);
      check(rise0[0]);
      check(n_rise[0]);
      check(high_last[0]);
      check(rise_last[0] - rise_prev[0]);
      check(rise0[1]);
      check(n_rise[1]);
      check(high_last[1]);
      check(rise_last[1] - rise_prev[1]);
      check(done_last[1]);
      check(n_done[1]);
      check(done_max[1]);
      check(n_rise[2]);
      check(done_last[2]);
      check(rise0[3]);
      check(high_last[3]);
      check(done_last[3]);
      check(int'(o_busy));

      // Re-arm halted channels via an enable toggle; ch0 keeps running throughout
      cfg(2, 4, 10, 0, 0);
      cfg(3, 1, 0, 0, 5);
      enable = 4'b0001;
      step(2);
      enable = 4'hF;
      step(2);
      send_tod(start_time);
      step(2);
      clear_stats();
      step(10 - ((cyc - c) % 10));
      c2 = cyc;
      pps = 1'b1;
      push("ch2_rise0", c2 + 4);
      push("ch2_drop_fall", c2 + 22);
      push("ch2_drop_ndone", 0);
      push("ch3_p0_rise0", c2 + 4);
      push("ch3_p0_high", 50);
      push("ch3_p0_done_t", c2 + 53);
      push("ch1_rearm_rise0", c2 + 74);
      push("ch0_keep_nrise", 2);
      push("ch0_keep_period", 100);
      push("prerst_pulse", 4'b0001);
      push("prerst_busy", 4'b0011);
      step(3);
      pps = 1'b0;
      step(17);
      enable = 4'b1011;
      step(130);
      check(rise0[2]);
      check(fall_last[2]);
      check(n_done[2]);
      check(rise0[3]);
      check(high_last[3]);
      check(done_last[3]);
      check(rise0[1]);
      check(n_rise[0]);
      check(rise_last[0] - rise_prev[0]);
      check(int'(o_pulse));
      check(int'(o_busy));

      // Reset in the middle of running trains
      rst = 1'b1;
      step(1);
      push("midrst_pulse", 0);
      push("midrst_busy", 0);
      push("midrst_done", 0);
      check(int'(o_pulse));
      check(int'(o_busy));
      check(int'(o_done));
      step(1);
      rst = 1'b0;
      cfg(0, 3, 10, 0, 2);
      step(3);

      // TOD match coincident with a PPS edge: that edge must not start the trains
      clear_stats();
      pps = 1'b1;
      step(2);
      send_tod(start_time);
      pps = 1'b0;
      step(30);
      push("coinc_rises", 0);
      push("coinc_busy", 4'b1011);
      check(n_rise[0] + n_rise[1] + n_rise[3]);
      check(int'(o_busy));

      // The next PPS starts them cleanly
      clear_stats();
      c3 = cyc;
      pps = 1'b1;
      push("post_ch0_rise0", c3 + 4);
      push("post_ch0_nrise", 2);
      push("post_ch0_done_t", c3 + 203);
      push("post_ch1_rise0", c3 + 74);
      push("post_ch3_done_t", c3 + 53);
      push("sb_drained", 0);
      step(3);
      pps = 1'b0;
      step(250);
      check(rise0[0]);
      check(n_rise[0]);
      check(done_last[0]);
      check(rise0[1]);
      check(done_last[3]);
      check(sb_q.size() - 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
